alu_cmd_issuer: RTL and testbench
=================================

ALU_CMD_ISSUER -- requirements
Module: alu_cmd_issuer

Interface
REQ-001: Parameter WIDTH, default 32, operand/result width in bits.
REQ-002: Parameter TAGW, default 4, command tag width in bits.
REQ-003: clk  input  1  single clock; all state updates on rising edge.
REQ-004: rst_n  input  1  reset; asynchronous, active-low.
REQ-005: cmdValid / cmdReady  input / output  1 / 1  upstream command handshake.
REQ-006: cmdOpcode  input  4  0=ADD, 1=SUB, 2=AND, 3=OR, 4=SLL; 5-15 illegal.
REQ-007: cmdOperandA / cmdOperandB  input  WIDTH each  operands.
REQ-008: cmdShift  input  5  shift amount for SLL.
REQ-009: cmdChain  input  1  when 1, last captured result replaces cmdOperandA.
REQ-010: cmdTag  input  TAGW  opaque ID, returned unchanged.
REQ-011: aluOpcode / aluInput1 / aluInput2 / aluShiftValue  output  4 / WIDTH / WIDTH / 5  registered drive to ALU.
REQ-012: aluResult / aluCarryFlag / aluZeroFlag / aluOverFlowFlag  input  WIDTH / 1 / 1 / 1  combinational ALU outputs.
REQ-013: rspValid / rspReady  output / input  1 / 1  downstream response handshake.
REQ-014: rspResult / rspCarry / rspZero / rspOverflow / rspError / rspTag  output  WIDTH / 1 / 1 / 1 / 1 / TAGW  response payload.
REQ-015: busy  output  1  high in any state other than IDLE.
REQ-016: opCount  output  16  count of completed responses.

Function
REQ-017: FSM states IDLE, DRIVE, RESP.
REQ-018: cmdReady = 1 only in IDLE; accept on cmdValid && cmdReady at a rising edge.
REQ-019: Legal accept: IDLE->DRIVE; ALU port registers load opcode, operands (chain applied), shift, on the accept edge.
REQ-020: DRIVE lasts exactly one cycle; at its closing edge capture aluResult and flags into response registers, go to RESP.
REQ-021: Latency: accept at edge N -> rspValid high from edge N+2.
REQ-022: Illegal opcode accept: IDLE->RESP directly (rspValid from edge N+1), rspError=1, rspResult=0, all flags 0, ALU port registers unchanged, last-result register unchanged.
REQ-023: rspCarry and rspOverflow forced 0 for AND/OR/SLL; passed through for ADD/SUB; rspZero passed for all legal ops.
REQ-024: Response payload and rspValid held stable while rspValid && !rspReady.
REQ-025: rspValid && rspReady at an edge: RESP->IDLE, rspValid drops, opCount increments (wraps 0xFFFF->0x0000).
REQ-026: No new command accepted in the same cycle a response completes; cmdReady rises the cycle after.
REQ-027: Last-result register updates with aluResult at DRIVE capture only; cmdChain with no prior legal op uses 0.
REQ-028: cmdValid in non-IDLE states is ignored; no command queued.

Reset
REQ-029: While rst_n=0: state IDLE, cmdReady=1 only after release? No -- cmdReady=0 during reset, 1 from first edge state is IDLE with rst_n=1.
REQ-030: Reset values: all alu* outputs 0, rspValid=0, all rsp* payload 0, busy=0, opCount=0, last-result=0.
REQ-031: Reset mid-operation drops the in-flight command; no response is ever produced for it.

Structure
REQ-032: Shared package holds opcode localparams (ADD..SLL), FSM state enum, and an is-legal-opcode function.
REQ-033: Flag masking (REQ-023) isolated in one sub-module alu_flag_mask; no other sub-modules; ALU itself instantiated only in the bench.

Verification
REQ-034: ADD A=0xFFFFFFFF B=0x1, rspReady=1 -> rspResult=0, rspCarry=1, rspZero=1, rspOverflow=0, rspValid at accept+2.
REQ-035: SUB A=0x80000000 B=0x1 -> rspResult=0x7FFFFFFF, rspOverflow=1; then chained ADD B=0x1 -> rspResult=0x80000000.
REQ-036: Opcode 7 tag 0x5 -> rspError=1, rspResult=0, rspTag=0x5 at accept+1; aluOpcode unchanged; opCount+1.
REQ-037: OR 0xF0,0x0F with rspReady=0 for 5 cycles -> payload 0xFF stable, cmdReady=0, extra cmdValid ignored; completes on rspReady.
REQ-038: Assert rst_n=0 during DRIVE -> rspValid never rises for that tag; all outputs at reset values immediately.
REQ-039: 65536 back-to-back AND ops -> opCount wraps to 0x0000.

Source files
------------

// File: rtl/alu_cmd_issuer_pkg.sv
// Shared definitions for the ALU command issuer: opcodes, FSM states and
// the opcode legality check.
package alu_cmd_issuer_pkg;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_SLL = 4'd4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_RESP  = 2'd2
   } state_t;

   function automatic logic is_legal_op(input logic [3:0] op);
      return (op <= OP_SLL);
   endfunction

endpackage

// File: rtl/alu_cmd_issuer_flag_mask.sv
// Carry/overflow only carry meaning for arithmetic ops; logical ops and
// shifts report them as 0.
module alu_flag_mask
   import alu_cmd_issuer_pkg::*;
(
   input  logic [3:0] opcode_i,
   input  logic       carry_i,
   input  logic       overflow_i,
   output logic       carry_o,
   output logic       overflow_o
);

   logic is_arith;

   assign is_arith   = (opcode_i == OP_ADD) || (opcode_i == OP_SUB);
   assign carry_o    = is_arith & carry_i;
   assign overflow_o = is_arith & overflow_i;

endmodule

// File: rtl/alu_cmd_issuer.sv
// Issues one command at a time to an external combinational ALU and returns
// the captured result with its tag over a valid/ready response channel.
module alu_cmd_issuer
   import alu_cmd_issuer_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int TAGW  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   // Both channels: a transfer happens on a rising edge where valid && ready;
   // the sender holds valid and payload stable until that edge.
   input  logic             cmdValid,
   output logic             cmdReady,
   input  logic [3:0]       cmdOpcode,
   input  logic [WIDTH-1:0] cmdOperandA,
   input  logic [WIDTH-1:0] cmdOperandB,
   input  logic [4:0]       cmdShift,
   input  logic             cmdChain,
   input  logic [TAGW-1:0]  cmdTag,
   output logic [3:0]       aluOpcode,
   output logic [WIDTH-1:0] aluInput1,
   output logic [WIDTH-1:0] aluInput2,
   output logic [4:0]       aluShiftValue,
   input  logic [WIDTH-1:0] aluResult,
   input  logic             aluCarryFlag,
   input  logic             aluZeroFlag,
   input  logic             aluOverFlowFlag,
   output logic             rspValid,
   input  logic             rspReady,
   output logic [WIDTH-1:0] rspResult,
   output logic             rspCarry,
   output logic             rspZero,
   output logic             rspOverflow,
   output logic             rspError,
   output logic [TAGW-1:0]  rspTag,
   output logic             busy,
   output logic [15:0]      opCount,
   output logic [1:0]       dbgState
);

   state_t           state_q, state_d;
   logic             ready_en_q;
   logic             accept, accept_legal, rsp_done;
   logic [3:0]       alu_op_q;
   logic [WIDTH-1:0] alu_in1_q, alu_in2_q, last_q;
   logic [4:0]       alu_shift_q;
   logic [WIDTH-1:0] rsp_result_q;
   logic             rsp_carry_q, rsp_zero_q, rsp_ovf_q, rsp_err_q;
   logic [TAGW-1:0]  rsp_tag_q;
   logic [15:0]      op_count_q, op_count_d;
   logic             mask_carry, mask_ovf;

   assign accept       = cmdValid && cmdReady;
   assign accept_legal = accept && is_legal_op(cmdOpcode);
   assign rsp_done     = (state_q == ST_RESP) && rspReady;
   assign op_count_d   = rsp_done ? op_count_q + 16'd1 : op_count_q;

   // ready_en_q keeps cmdReady low until the first edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         ready_en_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ready_en_q <= 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_legal)  state_d = ST_DRIVE;
            else if (accept)   state_d = ST_RESP;
         end
         ST_DRIVE: state_d = ST_RESP;
         ST_RESP:  if (rspReady) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cmdReady = (state_q == ST_IDLE) && ready_en_q;
      busy     = (state_q != ST_IDLE);
      rspValid = (state_q == ST_RESP);
      dbgState = state_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_op_q    <= '0;
         alu_in1_q   <= '0;
         alu_in2_q   <= '0;
         alu_shift_q <= '0;
         last_q      <= '0;
         op_count_q  <= '0;
      end else begin
         if (accept_legal) begin
            alu_op_q    <= cmdOpcode;
            alu_in1_q   <= cmdChain ? last_q : cmdOperandA;
            alu_in2_q   <= cmdOperandB;
            alu_shift_q <= cmdShift;
         end
         if (state_q == ST_DRIVE) last_q <= aluResult;
         op_count_q <= op_count_d;
      end
   end

   // Illegal opcodes produce an error response without touching the ALU.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_result_q <= '0;
         rsp_carry_q  <= 1'b0;
         rsp_zero_q   <= 1'b0;
         rsp_ovf_q    <= 1'b0;
         rsp_err_q    <= 1'b0;
         rsp_tag_q    <= '0;
      end else if (accept) begin
         rsp_tag_q <= cmdTag;
         if (!accept_legal) begin
            rsp_result_q <= '0;
            rsp_carry_q  <= 1'b0;
            rsp_zero_q   <= 1'b0;
            rsp_ovf_q    <= 1'b0;
            rsp_err_q    <= 1'b1;
         end
      end else if (state_q == ST_DRIVE) begin
         rsp_result_q <= aluResult;
         rsp_carry_q  <= mask_carry;
         rsp_zero_q   <= aluZeroFlag;
         rsp_ovf_q    <= mask_ovf;
         rsp_err_q    <= 1'b0;
      end
   end

   alu_flag_mask u_flag_mask (
      .opcode_i   (alu_op_q),
      .carry_i    (aluCarryFlag),
      .overflow_i (aluOverFlowFlag),
      .carry_o    (mask_carry),
      .overflow_o (mask_ovf)
   );

   assign aluOpcode     = alu_op_q;
   assign aluInput1     = alu_in1_q;
   assign aluInput2     = alu_in2_q;
   assign aluShiftValue = alu_shift_q;
   assign rspResult     = rsp_result_q;
   assign rspCarry      = rsp_carry_q;
   assign rspZero       = rsp_zero_q;
   assign rspOverflow   = rsp_ovf_q;
   assign rspError      = rsp_err_q;
   assign rspTag        = rsp_tag_q;
   assign opCount       = op_count_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: behavioural ALU, command driver, response
// scoreboard and directed plus random scenarios.
module tb_alu_cmd_issuer;

   localparam int W  = 32;
   localparam int TW = 4;
   localparam int EW = 4 + TW + W;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmdValid = 1'b0;
   logic          cmdReady;
   logic [3:0]    cmdOpcode = '0;
   logic [W-1:0]  cmdOperandA = '0, cmdOperandB = '0;
   logic [4:0]    cmdShift = '0;
   logic          cmdChain = 1'b0;
   logic [TW-1:0] cmdTag = '0;
   logic [3:0]    aluOpcode;
   logic [W-1:0]  aluInput1, aluInput2;
   logic [4:0]    aluShiftValue;
   logic [W-1:0]  aluResult;
   logic          aluCarryFlag, aluZeroFlag, aluOverFlowFlag;
   logic          rspValid;
   logic          rspReady = 1'b0;
   logic [W-1:0]  rspResult;
   logic          rspCarry, rspZero, rspOverflow, rspError;
   logic [TW-1:0] rspTag;
   logic          busy;
   logic [15:0]   opCount;
   logic [1:0]    dbgState;

   int total = 0;
   int bad   = 0;

   logic [EW-1:0] exp_q[$];
   int            lat_q[$];
   logic [W-1:0]  m_last = '0;
   logic [W-1:0]  m_in1  = '0;
   logic [3:0]    m_aluop = '0;
   logic [15:0]   m_count = '0;

   always #5 clk = ~clk;

   alu_cmd_issuer #(.WIDTH(W), .TAGW(TW)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdOpcode(cmdOpcode),
      .cmdOperandA(cmdOperandA), .cmdOperandB(cmdOperandB), .cmdShift(cmdShift),
      .cmdChain(cmdChain), .cmdTag(cmdTag),
      .aluOpcode(aluOpcode), .aluInput1(aluInput1), .aluInput2(aluInput2),
      .aluShiftValue(aluShiftValue), .aluResult(aluResult),
      .aluCarryFlag(aluCarryFlag), .aluZeroFlag(aluZeroFlag),
      .aluOverFlowFlag(aluOverFlowFlag),
      .rspValid(rspValid), .rspReady(rspReady), .rspResult(rspResult),
      .rspCarry(rspCarry), .rspZero(rspZero), .rspOverflow(rspOverflow),
      .rspError(rspError), .rspTag(rspTag), .busy(busy), .opCount(opCount),
      .dbgState(dbgState)
   );

   // Combinational ALU; logical ops deliberately raise carry/overflow.
   always_comb begin
      aluResult       = '0;
      aluCarryFlag    = 1'b0;
      aluOverFlowFlag = 1'b0;
      case (aluOpcode)
         4'd0: begin
            {aluCarryFlag, aluResult} = {1'b0, aluInput1} + {1'b0, aluInput2};
            aluOverFlowFlag = (aluInput1[W-1] == aluInput2[W-1]) && (aluResult[W-1] != aluInput1[W-1]);
         end
         4'd1: begin
            aluResult       = aluInput1 - aluInput2;
            aluCarryFlag    = (aluInput1 < aluInput2);
            aluOverFlowFlag = (aluInput1[W-1] != aluInput2[W-1]) && (aluResult[W-1] != aluInput1[W-1]);
         end
         4'd2: begin aluResult = aluInput1 & aluInput2; aluCarryFlag = 1'b1; aluOverFlowFlag = 1'b1; end
         4'd3: begin aluResult = aluInput1 | aluInput2; aluCarryFlag = 1'b1; aluOverFlowFlag = 1'b1; end
         4'd4: begin aluResult = aluInput1 << aluShiftValue; aluCarryFlag = 1'b1; aluOverFlowFlag = 1'b1; end
         default: begin aluResult = 32'hDEADBEEF; aluCarryFlag = 1'b1; aluOverFlowFlag = 1'b1; end
      endcase
      aluZeroFlag = (aluResult == '0);
   end

   // Expected payload {err, ovf, zero, carry, tag, result}.
   function automatic logic [EW-1:0] calc(input logic [3:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic [4:0] sh,
                                          input logic [TW-1:0] tag);
      logic [W:0]   t;
      logic [W-1:0] r;
      logic         c, v;
      t = '0; r = '0; c = 1'b0; v = 1'b0;
      case (op)
         4'd0: begin
            t = {1'b0, a} + {1'b0, b}; r = t[W-1:0]; c = t[W];
            v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
         end
         4'd1: begin
            t = {1'b0, a} - {1'b0, b}; r = t[W-1:0]; c = t[W];
            v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
         end
         4'd2: r = a & b;
         4'd3: r = a | b;
         4'd4: r = a << sh;
         default: r = '0;
      endcase
      if (op > 4'd4) return {1'b1, 1'b0, 1'b0, 1'b0, tag, {W{1'b0}}};
      return {1'b0, v, (r == '0), c, tag, r};
   endfunction

   task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [4:0] sh, input logic ch, input logic [TW-1:0] tag);
      logic [W-1:0] in1;
      logic [EW-1:0] e;
      int k;
      k = 0;
      @(negedge clk);
      while (!cmdReady && k < 20) begin
         @(negedge clk);
         k++;
      end
      total++;
      if (cmdReady !== 1'b1) begin
         $display("FAIL cmd_ready_wait got=%b want=1", cmdReady);
         bad++;
      end
      cmdOpcode = op; cmdOperandA = a; cmdOperandB = b; cmdShift = sh;
      cmdChain = ch; cmdTag = tag; cmdValid = 1'b1;
      in1 = ch ? m_last : a;
      e = calc(op, in1, b, sh, tag);
      exp_q.push_back(e);
      if (op <= 4'd4) begin
         m_last = e[W-1:0]; m_aluop = op; m_in1 = in1;
         lat_q.push_back(2);
      end else begin
         lat_q.push_back(1);
      end
      @(negedge clk);
      cmdValid = 1'b0; cmdChain = 1'b0;
      cmdOperandA = $urandom; cmdOperandB = $urandom;
   endtask

   task automatic collect(input int hold, input bit poke);
      logic [EW-1:0] e;
      int lat, k;
      e = exp_q.pop_front();
      lat = lat_q.pop_front();
      k = 1;
      while (!rspValid && k < 10) begin
         @(negedge clk);
         k++;
      end
      total++;
      if (rspValid !== 1'b1 || k != lat) begin
         $display("FAIL rsp_latency got=%0d valid=%b want=%0d", k, rspValid, lat);
         bad++;
      end
      total++;
      if (aluOpcode !== m_aluop || aluInput1 !== m_in1) begin
         $display("FAIL alu_ports got op=%0d in1=%h want op=%0d in1=%h", aluOpcode, aluInput1, m_aluop, m_in1);
         bad++;
      end
      total++;
      if ({rspError, rspOverflow, rspZero, rspCarry, rspTag, rspResult} !== e) begin
         $display("FAIL rsp_payload got=%h want=%h",
                  {rspError, rspOverflow, rspZero, rspCarry, rspTag, rspResult}, e);
         bad++;
      end
      for (int i = 0; i < hold; i++) begin
         if (poke) begin
            cmdValid = 1'b1; cmdOpcode = 4'($urandom_range(0, 4));
            cmdOperandA = $urandom; cmdOperandB = $urandom; cmdTag = 4'($urandom_range(0, 15));
         end
         @(negedge clk);
         total++;
         if ({rspError, rspOverflow, rspZero, rspCarry, rspTag, rspResult} !== e
             || rspValid !== 1'b1 || cmdReady !== 1'b0) begin
            $display("FAIL rsp_hold cyc=%0d got=%h valid=%b ready=%b want=%h valid=1 ready=0", i,
                     {rspError, rspOverflow, rspZero, rspCarry, rspTag, rspResult}, rspValid, cmdReady, e);
            bad++;
         end
      end
      cmdValid = 1'b0;
      rspReady = 1'b1;
      @(negedge clk);
      rspReady = 1'b0;
      m_count = m_count + 16'd1;
      total++;
      if (rspValid !== 1'b0 || opCount !== m_count || cmdReady !== 1'b1) begin
         $display("FAIL rsp_complete got valid=%b cnt=%h ready=%b want valid=0 cnt=%h ready=1",
                  rspValid, opCount, cmdReady, m_count);
         bad++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if ({cmdReady, busy, rspValid, opCount, aluOpcode, aluInput1, rspResult, rspTag, rspError} !== '0) begin
         $display("FAIL reset_values got rdy=%b busy=%b vld=%b cnt=%h op=%h", cmdReady, busy, rspValid, opCount, aluOpcode);
         bad++;
      end
      rst_n = 1'b1;
      #1;
      total++;
      if (cmdReady !== 1'b0) begin
         $display("FAIL ready_before_edge got=%b want=0", cmdReady);
         bad++;
      end
      @(negedge clk);
      total++;
      if (cmdReady !== 1'b1 || busy !== 1'b0) begin
         $display("FAIL ready_after_edge got rdy=%b busy=%b want rdy=1 busy=0", cmdReady, busy);
         bad++;
      end
   endtask

   task automatic test_directed();
      issue(4'd0, 32'hFFFFFFFF, 32'h1, 5'd0, 1'b0, 4'h1);
      collect(0, 1'b0);
      issue(4'd1, 32'h80000000, 32'h1, 5'd0, 1'b0, 4'h2);
      collect(0, 1'b0);
      issue(4'd0, 32'h12345678, 32'h1, 5'd0, 1'b1, 4'h3);
      collect(0, 1'b0);
      issue(4'd7, 32'h1, 32'h2, 5'd0, 1'b0, 4'h5);
      collect(0, 1'b0);
      issue(4'd4, 32'h1, 32'h0, 5'd31, 1'b0, 4'h6);
      collect(0, 1'b0);
      issue(4'd2, 32'h0F0F0000, 32'h0000F0F0, 5'd0, 1'b0, 4'h7);
      collect(0, 1'b0);
   endtask

   task automatic test_hold();
      issue(4'd3, 32'hF0, 32'h0F, 5'd0, 1'b0, 4'h8);
      collect(5, 1'b1);
   endtask

   task automatic test_random();
      for (int n = 0; n < 30; n++) begin
         int hold;
         hold = $urandom_range(0, 2);
         issue(4'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom_range(0, 31)),
               1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
         collect(hold, hold != 0);
      end
   endtask

   task automatic test_reset_mid();
      bit seen;
      issue(4'd0, 32'h11, 32'h22, 5'd0, 1'b0, 4'hA);
      rst_n = 1'b0;
      #1;
      total++;
      if ({cmdReady, busy, rspValid, opCount, aluOpcode, aluInput1, aluInput2, aluShiftValue,
           rspResult, rspCarry, rspZero, rspOverflow, rspError, rspTag} !== '0) begin
         $display("FAIL reset_mid_values got busy=%b vld=%b op=%h in1=%h cnt=%h", busy, rspValid, aluOpcode, aluInput1, opCount);
         bad++;
      end
      exp_q.delete(); lat_q.delete();
      m_last = '0; m_in1 = '0; m_aluop = '0; m_count = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (rspValid) seen = 1'b1;
      end
      total++;
      if (seen) begin
         $display("FAIL reset_mid_no_rsp got rspValid=1 want=0");
         bad++;
      end
      issue(4'd0, 32'hFFFF0000, 32'h5, 5'd0, 1'b1, 4'hB);
      collect(0, 1'b0);
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      dut.op_count_q = 16'hFFF0;
      m_count = 16'hFFF0;
      for (int n = 0; n < 20; n++) begin
         issue(4'd2, $urandom, $urandom, 5'd0, 1'b0, 4'(n));
         collect(0, 1'b0);
      end
      total++;
      if (opCount !== 16'h0004) begin
         $display("FAIL opcount_wrap got=%h want=0004", opCount);
         bad++;
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_directed();
      test_hold();
      test_random();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
